// File: rtl/keypoint_pkg.sv
// keypoint_pkg: shared types and width helpers for the keypoint readout path.
// Optional build macro used by keypoint_reader: KEYPOINT_TOP_COORDS_EN.
package keypoint_pkg;

  localparam int KP_DIMENSION        = 64;
  localparam int KP_NUMBER_KEYPOINTS = 1000;

  // Coordinate width for a square image of side dim.
  function automatic int coord_width(input int dim);
    return $clog2(dim);
  endfunction

  // Address width for a memory holding n entries.
  function automatic int addr_width(input int n);
    return $clog2(n);
  endfunction

  localparam int KP_CW = coord_width(KP_DIMENSION);

  // Same bit layout as the keypoint BRAM word: {octave, x, y}.
  typedef struct packed {
    logic             octave;
    logic [KP_CW-1:0] x;
    logic [KP_CW-1:0] y;
  } keypoint_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_t;

endpackage

// File: rtl/keypoint_reader_if.sv
// keypoint_reader_if: valid/ready keypoint record stream.
// master drives records, slave applies backpressure through kp_ready.
interface keypoint_reader_if
  import keypoint_pkg::*;
#(
  parameter int CW = KP_CW
);
  logic          kp_valid;
  logic          kp_ready;
  logic          kp_octave;
  logic [CW-1:0] kp_x;
  logic [CW-1:0] kp_y;

  modport master (output kp_valid, output kp_octave, output kp_x, output kp_y, input kp_ready);
  modport slave  (input kp_valid, input kp_octave, input kp_x, input kp_y, output kp_ready);
endinterface

// File: rtl/keypoint_fifo.sv
// keypoint_fifo: small synchronous FIFO with occupancy count.
// A push while full is accepted only together with a pop in the same cycle.
module keypoint_fifo
  import keypoint_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type item_t = keypoint_t,
  localparam int CNTW   = $clog2(DEPTH + 1),
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst_in,
  input  logic            push,
  input  item_t           push_data,
  input  logic            pop,
  output item_t           pop_data,
  output logic            full,
  output logic            empty,
  output logic [CNTW-1:0] count
);

  item_t           mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CNTW-1:0] count_r;
  logic            do_push_s;
  logic            do_pop_s;

  // Wrap a pointer at DEPTH (depth need not be a power of two).
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return PW'(0);
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign empty    = (count_r == CNTW'(0));
  assign full     = (count_r == CNTW'(DEPTH));
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Qualify requests against current occupancy.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Storage write; data needs no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CNTW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNTW'(1);
        2'b01:   count_r <= count_r - CNTW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/keypoint_reader.sv
// keypoint_reader: drains the keypoint BRAM (port B) after detection and
// streams {octave, x, y} records over a valid/ready interface. Reads are
// issued only against free output-buffer credits so the 2-cycle BRAM latency
// is absorbed under backpressure.
// Build macro KEYPOINT_TOP_COORDS_EN: octave-2 records are emitted with
// coordinates doubled onto the top-octave grid.
module keypoint_reader
  import keypoint_pkg::*;
#(
  parameter int  DIMENSION        = KP_DIMENSION,
  parameter int  NUMBER_KEYPOINTS = KP_NUMBER_KEYPOINTS,
  parameter int  READ_LATENCY     = 2,
  parameter int  FIFO_DEPTH       = 4,
  localparam int CW               = coord_width(DIMENSION),
  localparam int AW               = addr_width(NUMBER_KEYPOINTS)
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              start,
  input  logic [AW:0]       key_count,
  output logic [AW-1:0]     key_read_addr,
  input  logic [2*CW:0]     key_read_data,
  keypoint_reader_if.master kp,
  output logic              busy,
  output logic              done
);

  typedef struct packed {
    logic          octave;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } rec_t;

  localparam int          OW        = $clog2(FIFO_DEPTH + 1);
  localparam int          SW        = OW + 1;
  localparam logic [AW:0] COUNT_MAX = (AW + 1)'(NUMBER_KEYPOINTS);

  reader_state_t         state_r, state_next_s;
  logic                  start_d_r;
  logic [AW:0]           count_r;
  logic [AW-1:0]         addr_r;
  logic [READ_LATENCY-1:0] tag_r;
  logic [OW-1:0]         in_flight_r;
  logic                  busy_r, done_r;

  logic [AW:0]           count_in_s;
  logic                  start_rise_s, load_s, credit_ok_s, issue_s, last_issue_s;
  logic                  push_s, pop_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic [OW-1:0]         fifo_count_s;
  rec_t                  head_s;

  // Request decode: edge detect, count clamp, credit check, read issue.
  always_comb begin
    if (key_count > COUNT_MAX) begin
      count_in_s = COUNT_MAX;
    end else begin
      count_in_s = key_count;
    end
    start_rise_s = start && !start_d_r;
    load_s       = (state_r == IDLE) && start_rise_s && (count_in_s != (AW + 1)'(0));
    credit_ok_s  = !fifo_full_s &&
                   (({1'b0, in_flight_r} + {1'b0, fifo_count_s}) < SW'(FIFO_DEPTH));
    issue_s      = (state_r == FETCH) && credit_ok_s;
    last_issue_s = ({1'b0, addr_r} == (count_r - (AW + 1)'(1)));
    push_s       = tag_r[READ_LATENCY-1];
    pop_s        = !fifo_empty_s && kp.kp_ready;
  end

  // Next-state logic; DRAIN exits in the cycle the final record is accepted.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_rise_s) begin
          if (count_in_s != (AW + 1)'(0)) begin
            state_next_s = FETCH;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        if (issue_s && last_issue_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = FETCH;
        end
      end
      DRAIN: begin
        if ((in_flight_r == OW'(0)) &&
            (fifo_empty_s || ((fifo_count_s == OW'(1)) && pop_s))) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Control registers: state, start history, count/address, status outputs.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_r   <= IDLE;
      start_d_r <= 1'b0;
      count_r   <= (AW + 1)'(0);
      addr_r    <= AW'(0);
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      start_d_r <= start;
      busy_r    <= (state_next_s == FETCH) || (state_next_s == DRAIN);
      done_r    <= (state_next_s == DONE);
      if (load_s) begin
        count_r <= count_in_s;
        addr_r  <= AW'(0);
      end else if (issue_s) begin
        addr_r  <= addr_r + AW'(1);
      end
    end
  end

  // Read-latency tag pipeline and outstanding-read counter.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      tag_r       <= '0;
      in_flight_r <= OW'(0);
    end else begin
      tag_r[0] <= issue_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
      case ({issue_s, push_s})
        2'b10:   in_flight_r <= in_flight_r + OW'(1);
        2'b01:   in_flight_r <= in_flight_r - OW'(1);
        default: in_flight_r <= in_flight_r;
      endcase
    end
  end

  keypoint_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .item_t (rec_t)
  ) u_fifo (
    .clk       (clk),
    .rst_in    (rst_in),
    .push      (push_s),
    .push_data (rec_t'(key_read_data)),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Output record from the FIFO head; valid depends only on stored occupancy.
  always_comb begin
    kp.kp_valid  = !fifo_empty_s;
    kp.kp_octave = head_s.octave;
`ifdef KEYPOINT_TOP_COORDS_EN
    if (head_s.octave) begin
      kp.kp_x = {head_s.x[CW-2:0], 1'b0};
      kp.kp_y = {head_s.y[CW-2:0], 1'b0};
    end else begin
      kp.kp_x = head_s.x;
      kp.kp_y = head_s.y;
    end
`else
    kp.kp_x = head_s.x;
    kp.kp_y = head_s.y;
`endif
  end

  assign key_read_addr = addr_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule
